// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: a scoreboard of in-flight destinations drives stall, branch flush and EXE forward selects.
// Build option FORWARDING_EN: load-use-only stalls plus EXE operand forwarding; without it every RAW hazard stalls.
module hazard_fwd_ctrl #(
   parameter int REG_AW     = 4,
   parameter int DEPTH      = 3,
   parameter int LOAD_READY = 2,
   parameter int FLUSH_LEN  = 1,
   parameter int FWD_W      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_src1,
   input  logic [REG_AW-1:0] id_src2,
   input  logic              id_src1_en,
   input  logic              id_src2_en,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_wb_en,
   input  logic              id_mem_read,
   input  logic              branch_taken,
   output logic              stall,
   output logic              flush_if,
   output logic              flush_id,
   output logic [FWD_W-1:0]  fwd_sel1,
   output logic [FWD_W-1:0]  fwd_sel2,
   output logic [15:0]       stall_cnt
);

   logic [DEPTH-1:0]  sb_valid_q, sb_valid_d;
   logic [DEPTH-1:0]  sb_load_q, sb_load_d;
   logic [REG_AW-1:0] sb_dest_q [DEPTH];
   logic [REG_AW-1:0] sb_dest_d [DEPTH];
   logic [3:0]        flush_ctr_q, flush_ctr_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;
   logic [DEPTH-1:0]  stall_elig;
   logic              flush;
   logic              hazard;

   // Entry DEPTH-1 is WB: the register file bypasses it, so it is never a stall source.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
`ifdef FORWARDING_EN
         stall_elig[k] = sb_load_q[k] && (k + 1 < LOAD_READY) && (k < DEPTH - 1);
`else
         stall_elig[k] = (k < DEPTH - 1);
`endif
      end
   end

   always_comb begin
      flush  = branch_taken | (flush_ctr_q != 4'd0);
      hazard = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (sb_valid_q[k] && stall_elig[k] &&
             ((id_src1_en && (sb_dest_q[k] == id_src1)) ||
              (id_src2_en && (sb_dest_q[k] == id_src2))))
            hazard = 1'b1;
      end
      stall = id_valid & ~flush & hazard;
   end

   always_comb begin
      sb_valid_d   = {sb_valid_q[DEPTH-2:0], id_valid & id_wb_en & ~stall & ~flush};
      sb_load_d    = {sb_load_q[DEPTH-2:0], id_mem_read};
      sb_dest_d[0] = id_dest;
      for (int k = 1; k < DEPTH; k++)
         sb_dest_d[k] = sb_dest_q[k-1];
      if (branch_taken)
         flush_ctr_d = 4'(FLUSH_LEN - 1);
      else if (flush_ctr_q != 4'd0)
         flush_ctr_d = flush_ctr_q - 4'd1;
      else
         flush_ctr_d = 4'd0;
      stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb_valid_q  <= '0;
         sb_load_q   <= '0;
         for (int k = 0; k < DEPTH; k++)
            sb_dest_q[k] <= '0;
         flush_ctr_q <= 4'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         sb_valid_q  <= sb_valid_d;
         sb_load_q   <= sb_load_d;
         for (int k = 0; k < DEPTH; k++)
            sb_dest_q[k] <= sb_dest_d[k];
         flush_ctr_q <= flush_ctr_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign flush_if  = flush;
   assign flush_id  = flush;
   assign stall_cnt = stall_cnt_q;

`ifdef FORWARDING_EN
   logic [REG_AW-1:0] ex_src1_q, ex_src1_d, ex_src2_q, ex_src2_d;
   logic              ex_en1_q, ex_en1_d, ex_en2_q, ex_en2_d;

   // Scan oldest to youngest so the youngest matching producer overrides.
   always_comb begin
      ex_src1_d = id_src1;
      ex_src2_d = id_src2;
      ex_en1_d  = id_src1_en & ~stall & ~flush;
      ex_en2_d  = id_src2_en & ~stall & ~flush;
      fwd_sel1  = '0;
      fwd_sel2  = '0;
      for (int k = DEPTH - 1; k >= 1; k--) begin
         if (ex_en1_q && sb_valid_q[k] && (sb_dest_q[k] == ex_src1_q))
            fwd_sel1 = FWD_W'(k);
         if (ex_en2_q && sb_valid_q[k] && (sb_dest_q[k] == ex_src2_q))
            fwd_sel2 = FWD_W'(k);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_src1_q <= '0;
         ex_src2_q <= '0;
         ex_en1_q  <= 1'b0;
         ex_en2_q  <= 1'b0;
      end else begin
         ex_src1_q <= ex_src1_d;
         ex_src2_q <= ex_src2_d;
         ex_en1_q  <= ex_en1_d;
         ex_en2_q  <= ex_en2_d;
      end
   end
`else
   logic unused_load_bits;
   assign unused_load_bits = ^sb_load_q;
   assign fwd_sel1 = '0;
   assign fwd_sel2 = '0;
`endif

endmodule
